// File: rtl/freq_meter_if.sv
// Signal and result bundle for freq_meter: the measured input and enable in,
// the per-window result and status out.
interface freq_meter_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 i_sig;
    logic                 i_enable;
    logic [CNT_WIDTH-1:0] o_count;
    logic                 o_valid;
    logic                 o_overflow;
    logic                 o_nosig;
    logic                 o_busy;

    // master drives the measured signal and consumes results; slave is the meter
    modport master (
        output i_sig, i_enable,
        input  o_count, o_valid, o_overflow, o_nosig, o_busy
    );

    modport slave (
        input  i_sig, i_enable,
        output o_count, o_valid, o_overflow, o_nosig, o_busy
    );
endinterface

// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of an asynchronous input over a
// GATE_CYCLES window that starts on an input edge, one result strobe per window.
module freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_WIDTH   = 32,
    parameter int GATE_WIDTH  = 26,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    freq_meter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        GATE,
        DONE
    } state_t;

    localparam logic [GATE_WIDTH-1:0] GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_dly;
    logic                   sig_edge;
    logic [GATE_WIDTH-1:0]  gate_cnt;
    logic [CNT_WIDTH-1:0]   edge_cnt;
    logic                   ovf_flag;

    logic                   gate_end;
    logic                   clr_gate;
    logic                   start_win;
    logic                   publish;
    logic                   timeout;
    logic                   cnt_hit;
    logic [CNT_WIDTH-1:0]   cnt_nxt;
    logic                   ovf_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            sig_dly <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.i_sig};
            sig_dly <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sig_edge = sync_q[SYNC_STAGES-1] & ~sig_dly;
    assign gate_end = (gate_cnt == GATE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        clr_gate  = 1'b0;
        start_win = 1'b0;
        publish   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_enable) begin
                    state_nxt = ARM;
                    clr_gate  = 1'b1;
                end
            end
            ARM: begin
                if (!bus.i_enable) begin
                    state_nxt = IDLE;
                end else if (sig_edge) begin
                    state_nxt = GATE;
                    start_win = 1'b1;
                end else if (gate_end) begin
                    state_nxt = DONE;
                    publish   = 1'b1;
                    timeout   = 1'b1;
                end
            end
            GATE: begin
                if (!bus.i_enable) begin
                    state_nxt = IDLE;
                end else if (gate_end) begin
                    state_nxt = DONE;
                    publish   = 1'b1;
                end
            end
            DONE: begin
                // an edge seen in this cycle is deliberately dropped
                if (bus.i_enable) begin
                    state_nxt = ARM;
                    clr_gate  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Saturating edge count including an edge in the current gate cycle, so the
    // published result covers the final cycle of the window.
    always_comb begin
        cnt_hit = (state == GATE) && sig_edge;
        cnt_nxt = edge_cnt;
        ovf_nxt = ovf_flag;
        if (cnt_hit) begin
            if (edge_cnt == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = edge_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
        end else begin
            if (clr_gate || start_win) begin
                gate_cnt <= '0;
            end else if (state == ARM || state == GATE) begin
                gate_cnt <= gate_cnt + 1'b1;
            end

            if (start_win) begin
                edge_cnt <= '0;
                ovf_flag <= 1'b0;
            end else begin
                edge_cnt <= cnt_nxt;
                ovf_flag <= ovf_nxt;
            end
        end
    end

    // Results land on the transition into DONE, so o_valid is high exactly
    // during the DONE cycle with the new values already visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_count    <= '0;
            bus.o_overflow <= 1'b0;
            bus.o_nosig    <= 1'b0;
            bus.o_valid    <= 1'b0;
        end else begin
            bus.o_valid <= publish;
            if (publish) begin
                bus.o_count    <= timeout ? '0 : cnt_nxt;
                bus.o_overflow <= timeout ? 1'b0 : ovf_nxt;
                bus.o_nosig    <= timeout;
            end
        end
    end

    assign bus.o_busy = (state == ARM) || (state == GATE);

endmodule
